// File: rtl/cta_pkg.sv
// cta_pkg: shared state encoding, default sizes and a one-hot to index helper
// for the counter/timer arbiter.
package cta_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_CNT_W = 4;

    // Highest set bit wins; callers only pass one-hot or zero vectors.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++)
            if (oh[i]) idx = 3'(i);
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; the requester at ptr has top
// priority, then ptr+1, ... wrapping around N_REQ.
module rr_arbiter
    import cta_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx
);

    int j;

    // Scan from the farthest offset down so the nearest requester overwrites last.
    always_comb begin
        gnt = '0;
        j   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_REQ;
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
            end
        end
    end

    assign idx = IW'(onehot_to_idx(8'(gnt)));

endmodule

// File: rtl/counter_timer_arbiter.sv
// counter_timer_arbiter: one shared up-counter lent round-robin to N_REQ requesters
// as a cycle timer. Define CTA_ABORT_EN to abort a job when its owner drops req.
module counter_timer_arbiter
    import cta_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    parameter  int CNT_W = DEF_CNT_W,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] req_len,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [CNT_W-1:0]       count
);

    state_t             state;
    logic [CNT_W-1:0]   len;
    logic [CNT_W-1:0]   last;
    logic [CNT_W-1:0]   len_sel;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      win;
    logic [IW-1:0]      nxt_ptr;
    logic [N_REQ-1:0]   arb_gnt;
    logic [IW-1:0]      arb_idx;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_comb begin
        len_sel = '0;
        for (int i = 0; i < N_REQ; i++)
            if (arb_idx == IW'(i)) len_sel = req_len[i*CNT_W +: CNT_W];
    end

    // len==0 makes last wrap to all-ones, giving a full 2**CNT_W cycle job.
    assign last    = len - CNT_W'(1);
    assign nxt_ptr = (win == IW'(N_REQ - 1)) ? '0 : win + IW'(1);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= '0;
            done  <= '0;
            count <= '0;
            len   <= '0;
            ptr   <= '0;
            win   <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt   <= arb_gnt;
                        win   <= arb_idx;
                        len   <= len_sel;
                        count <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
`ifdef CTA_ABORT_EN
                    if (!req[win]) begin
                        gnt   <= '0;
                        count <= '0;
                        ptr   <= nxt_ptr;
                        state <= IDLE;
                    end else
`endif
                    if (count == last) begin
                        done  <= gnt;
                        state <= DONE;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                DONE: begin
                    gnt   <= '0;
                    count <= '0;
                    ptr   <= nxt_ptr;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_gnt_onehot:  assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
    a_done_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(done));
    a_done_owner:  assert property (@(posedge clk) disable iff (reset) |done |-> gnt == done);

endmodule

// File: tb/tb_counter_timer_arbiter.sv
// tb_counter_timer_arbiter: directed scenarios with hand-computed expectations
// for the shared counter/timer arbiter (honours CTA_ABORT_EN when defined).
module tb_counter_timer_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] req_len = '0;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  count;
    int checks = 0;
    int failures = 0;

    counter_timer_arbiter dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .req_len (req_len),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .count   (count)
    );

    always #5 clk = ~clk;

    // observed vector is {gnt, done, busy, count}
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req = 4'b1111;
        reset = 1'b1;
        tick();
        checks++;
        if ({gnt, done, busy, count} !== 13'h0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", {gnt, done, busy, count}, 13'h0);
        end
        req = '0;
        reset = 1'b0;
        tick();
        checks++;
        if ({gnt, done, busy, count} !== 13'h0) begin
            failures++;
            $display("FAIL reset_idle got=%h exp=%h", {gnt, done, busy, count}, 13'h0);
        end
    endtask

    task automatic test_single();
        req_len[3:0] = 4'd3;
        req = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 0) req_len[3:0] = 4'd15;
            checks++;
            if ({gnt, done, busy, count} !== {4'b0001, 4'b0000, 1'b1, 4'(c)}) begin
                failures++;
                $display("FAIL single_run c=%0d got=%h exp=%h", c, {gnt, done, busy, count},
                         {4'b0001, 4'b0000, 1'b1, 4'(c)});
            end
        end
        tick();
        checks++;
        if ({gnt, done, busy, count} !== {4'b0001, 4'b0001, 1'b1, 4'd2}) begin
            failures++;
            $display("FAIL single_done got=%h exp=%h", {gnt, done, busy, count},
                     {4'b0001, 4'b0001, 1'b1, 4'd2});
        end
        req = '0;
        tick();
        checks++;
        if ({gnt, done, busy, count} !== 13'h0) begin
            failures++;
            $display("FAIL single_idle got=%h exp=%h", {gnt, done, busy, count}, 13'h0);
        end
    endtask

    task automatic test_rr();
        pulse_reset();
        req_len = 16'h1111;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({gnt, done, busy, count} !== {4'(1 << (i % 4)), 4'b0000, 1'b1, 4'd0}) begin
                failures++;
                $display("FAIL rr_gnt i=%0d got=%h exp=%h", i, {gnt, done, busy, count},
                         {4'(1 << (i % 4)), 4'b0000, 1'b1, 4'd0});
            end
            tick();
            checks++;
            if ({gnt, done} !== {4'(1 << (i % 4)), 4'(1 << (i % 4))}) begin
                failures++;
                $display("FAIL rr_done i=%0d got=%h exp=%h", i, {gnt, done},
                         {4'(1 << (i % 4)), 4'(1 << (i % 4))});
            end
            tick();
            if (i == 4) req = '0;
            checks++;
            if ({gnt, done, busy, count} !== 13'h0) begin
                failures++;
                $display("FAIL rr_gap i=%0d got=%h exp=%h", i, {gnt, done, busy, count}, 13'h0);
            end
        end
    endtask

    task automatic test_wrap();
        req_len[7:4] = 4'd0;
        req = 4'b0010;
        tick();
        checks++;
        if ({gnt, count} !== {4'b0010, 4'd0}) begin
            failures++;
            $display("FAIL wrap_start got=%h exp=%h", {gnt, count}, {4'b0010, 4'd0});
        end
        for (int c = 1; c < 16; c++) begin
            tick();
            checks++;
            if ({done, count} !== {4'b0000, 4'(c)}) begin
                failures++;
                $display("FAIL wrap_count c=%0d got=%h exp=%h", c, {done, count}, {4'b0000, 4'(c)});
            end
        end
        tick();
        checks++;
        if ({gnt, done, count} !== {4'b0010, 4'b0010, 4'd15}) begin
            failures++;
            $display("FAIL wrap_done got=%h exp=%h", {gnt, done, count}, {4'b0010, 4'b0010, 4'd15});
        end
        req = '0;
        tick();
        checks++;
        if ({gnt, done, busy, count} !== 13'h0) begin
            failures++;
            $display("FAIL wrap_idle got=%h exp=%h", {gnt, done, busy, count}, 13'h0);
        end
    endtask

    task automatic test_late();
        req_len = 16'h0104;
        req = 4'b0001;
        tick();
        req = 4'b0101;
        for (int c = 1; c < 4; c++) begin
            tick();
            checks++;
            if ({gnt, done, count} !== {4'b0001, 4'b0000, 4'(c)}) begin
                failures++;
                $display("FAIL late_run c=%0d got=%h exp=%h", c, {gnt, done, count},
                         {4'b0001, 4'b0000, 4'(c)});
            end
        end
        tick();
        checks++;
        if ({gnt, done} !== {4'b0001, 4'b0001}) begin
            failures++;
            $display("FAIL late_done0 got=%h exp=%h", {gnt, done}, {4'b0001, 4'b0001});
        end
        req = 4'b0100;
        tick();
        checks++;
        if ({gnt, busy} !== {4'b0000, 1'b0}) begin
            failures++;
            $display("FAIL late_gap got=%h exp=%h", {gnt, busy}, {4'b0000, 1'b0});
        end
        tick();
        checks++;
        if ({gnt, count} !== {4'b0100, 4'd0}) begin
            failures++;
            $display("FAIL late_gnt2 got=%h exp=%h", {gnt, count}, {4'b0100, 4'd0});
        end
        tick();
        checks++;
        if (done !== 4'b0100) begin
            failures++;
            $display("FAIL late_done2 got=%b exp=%b", done, 4'b0100);
        end
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        req_len = 16'h1118;
        req = 4'b0001;
        for (int c = 0; c < 6; c++) tick();
        checks++;
        if ({gnt, count} !== {4'b0001, 4'd5}) begin
            failures++;
            $display("FAIL rmid_pre got=%h exp=%h", {gnt, count}, {4'b0001, 4'd5});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({gnt, done, busy, count} !== 13'h0) begin
            failures++;
            $display("FAIL rmid_async got=%h exp=%h", {gnt, done, busy, count}, 13'h0);
        end
        tick();
        checks++;
        if ({gnt, done, busy, count} !== 13'h0) begin
            failures++;
            $display("FAIL rmid_hold got=%h exp=%h", {gnt, done, busy, count}, 13'h0);
        end
        req = 4'b1010;
        reset = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            failures++;
            $display("FAIL rmid_ptr0 got=%b exp=%b", gnt, 4'b0010);
        end
        req = '0;
        pulse_reset();
    endtask

    task automatic test_abort();
        req_len = 16'h0005;
        req = 4'b0001;
        for (int c = 0; c < 3; c++) tick();
        checks++;
        if ({gnt, count} !== {4'b0001, 4'd2}) begin
            failures++;
            $display("FAIL abort_pre got=%h exp=%h", {gnt, count}, {4'b0001, 4'd2});
        end
        req = '0;
`ifdef CTA_ABORT_EN
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({gnt, done, busy, count} !== 13'h0) begin
                failures++;
                $display("FAIL abort_idle c=%0d got=%h exp=%h", c, {gnt, done, busy, count}, 13'h0);
            end
        end
`else
        tick();
        tick();
        checks++;
        if ({gnt, done, count} !== {4'b0001, 4'b0000, 4'd4}) begin
            failures++;
            $display("FAIL noabort_run got=%h exp=%h", {gnt, done, count}, {4'b0001, 4'b0000, 4'd4});
        end
        tick();
        checks++;
        if ({gnt, done, count} !== {4'b0001, 4'b0001, 4'd4}) begin
            failures++;
            $display("FAIL noabort_done got=%h exp=%h", {gnt, done, count}, {4'b0001, 4'b0001, 4'd4});
        end
        tick();
        checks++;
        if ({gnt, done, busy, count} !== 13'h0) begin
            failures++;
            $display("FAIL noabort_idle got=%h exp=%h", {gnt, done, busy, count}, 13'h0);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_wrap();
        test_late();
        test_reset_mid();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
